// File: rtl/riscv_base_csr_pkg.sv
// Shared CSR addresses, mstatus field positions, interrupt indices and the
// trap sequencer state type.
package riscv_base_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_MTI = 7;
  localparam int unsigned IRQ_MEI = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_EPC,
    ST_WR_CAUSE,
    ST_WR_TVAL,
    ST_WR_STATUS,
    ST_MRET_STATUS,
    ST_REDIRECT
  } trap_state_t;

  // mstatus on trap entry: stack MIE into MPIE, disable, record M-mode
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus on MRET: restore MIE from MPIE, set MPIE, stay in M-mode
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/riscv_base_irq_prio.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > others (lowest first).
module riscv_base_irq_prio
  import riscv_base_csr_pkg::*;
#(
  parameter int unsigned IRQ_W = 32
) (
  input  logic [IRQ_W-1:0] i_irq,
  output logic             o_valid,
  output logic [4:0]       o_idx
);

  // Widen so the fixed indices are always addressable for narrow vectors
  localparam int unsigned EXT_W = (IRQ_W > 12) ? IRQ_W : 12;

  logic [EXT_W-1:0] w_irq;
  logic             w_found;

  assign w_irq   = EXT_W'(i_irq);
  assign o_valid = |i_irq;

  // Lowest generic index first, then the named sources override in rising priority
  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < EXT_W; i++) begin
      if (!w_found && w_irq[i] && i != IRQ_MSI && i != IRQ_MTI && i != IRQ_MEI) begin
        o_idx   = 5'(i);
        w_found = 1'b1;
      end
    end
    if (w_irq[IRQ_MTI]) o_idx = 5'(IRQ_MTI);
    if (w_irq[IRQ_MSI]) o_idx = 5'(IRQ_MSI);
    if (w_irq[IRQ_MEI]) o_idx = 5'(IRQ_MEI);
  end

endmodule

// File: rtl/riscv_base_trap_seq.sv
// Trap/return sequencer owning the CSR write port: writes mepc, mcause,
// mtval and mstatus on a trap (or mstatus on MRET), then redirects once.
module riscv_base_trap_seq
  import riscv_base_csr_pkg::*;
#(
  parameter bit          SUPPORT_VECTORED = 1'b1,
  parameter int unsigned IRQ_W            = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [5:0]       exception_i,
  input  logic [31:0]      exception_pc_i,
  input  logic [31:0]      exception_addr_i,
  input  logic             mret_i,
  input  logic [IRQ_W-1:0] irq_pending_i,
  input  logic             mie_global_i,
  input  logic [31:0]      status_i,
  input  logic [31:0]      mtvec_i,
  input  logic [31:0]      mepc_i,
  input  logic             pipe_csr_we_i,
  input  logic [11:0]      pipe_csr_waddr_i,
  input  logic [31:0]      pipe_csr_wdata_i,
  output logic             pipe_csr_ready_o,
  output logic             csr_we_o,
  output logic [11:0]      csr_waddr_o,
  output logic [31:0]      csr_wdata_o,
  output logic             stall_o,
  output logic             csr_branch_o,
  output logic [31:0]      csr_target_o,
  output logic             busy_o
);

  trap_state_t r_state;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;
  logic        r_is_irq;
  logic        r_is_mret;

  logic        w_irq_valid;
  logic [4:0]  w_irq_idx;
  logic        w_idle;
  logic        w_take_exc;
  logic        w_take_irq;
  logic        w_take_mret;
  logic        w_start;
  logic [31:0] w_base;
  logic        w_unused_pc_lsb;

  riscv_base_irq_prio #(
    .IRQ_W (IRQ_W)
  ) u_prio (
    .i_irq   (irq_pending_i),
    .o_valid (w_irq_valid),
    .o_idx   (w_irq_idx)
  );

  // Gating with rst_in keeps every output quiet while reset is held
  assign w_idle      = (r_state == ST_IDLE) && rst_in;
  assign w_take_exc  = w_idle && (exception_i != '0);
  assign w_take_irq  = w_idle && !w_take_exc && mie_global_i && w_irq_valid;
  assign w_take_mret = w_idle && !w_take_exc && !w_take_irq && mret_i;
  assign w_start     = w_take_exc || w_take_irq || w_take_mret;

  assign busy_o           = (r_state != ST_IDLE);
  assign stall_o          = w_start || busy_o;
  assign csr_branch_o     = (r_state == ST_REDIRECT);
  assign pipe_csr_ready_o = w_idle && !w_start;
  assign w_base           = {mtvec_i[31:2], 2'b00};
  assign w_unused_pc_lsb  = ^exception_pc_i[1:0];

  // Sequencer state and trap context latched at the start cycle
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_cause   <= '0;
      r_tval    <= '0;
      r_is_irq  <= 1'b0;
      r_is_mret <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_exc) begin
            r_pc      <= {exception_pc_i[31:2], 2'b00};
            r_cause   <= {26'b0, exception_i};
            r_tval    <= exception_addr_i;
            r_is_irq  <= 1'b0;
            r_is_mret <= 1'b0;
            r_state   <= ST_WR_EPC;
          end else if (w_take_irq) begin
            r_pc      <= {exception_pc_i[31:2], 2'b00};
            r_cause   <= {1'b1, 26'b0, w_irq_idx};
            r_tval    <= '0;
            r_is_irq  <= 1'b1;
            r_is_mret <= 1'b0;
            r_state   <= ST_WR_EPC;
          end else if (w_take_mret) begin
            r_is_irq  <= 1'b0;
            r_is_mret <= 1'b1;
            r_state   <= ST_MRET_STATUS;
          end
        end
        ST_WR_EPC:      r_state <= ST_WR_CAUSE;
        ST_WR_CAUSE:    r_state <= ST_WR_TVAL;
        ST_WR_TVAL:     r_state <= ST_WR_STATUS;
        ST_WR_STATUS:   r_state <= ST_REDIRECT;
        ST_MRET_STATUS: r_state <= ST_REDIRECT;
        ST_REDIRECT:    r_state <= ST_IDLE;
        default:        r_state <= ST_IDLE;
      endcase
    end
  end

  // CSR write port: sequencer writes in its write states, pipeline otherwise
  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    case (r_state)
      ST_WR_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = r_pc;
      end
      ST_WR_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = r_cause;
      end
      ST_WR_TVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MTVAL;
        csr_wdata_o = r_tval;
      end
      ST_WR_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = trap_mstatus(status_i);
      end
      ST_MRET_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mret_mstatus(status_i);
      end
      default: begin
        if (pipe_csr_ready_o) begin
          csr_we_o    = pipe_csr_we_i;
          csr_waddr_o = pipe_csr_waddr_i;
          csr_wdata_o = pipe_csr_wdata_i;
        end
      end
    endcase
  end

  // Redirect target, only driven during the redirect pulse
  always_comb begin
    csr_target_o = '0;
    if (r_state == ST_REDIRECT) begin
      if (r_is_mret) begin
        csr_target_o = mepc_i;
      end else if (SUPPORT_VECTORED && (mtvec_i[1:0] == 2'b01) && r_is_irq) begin
        csr_target_o = w_base + {25'b0, r_cause[4:0], 2'b00};
      end else begin
        csr_target_o = w_base;
      end
    end
  end

endmodule
